// File: rtl/fetch_stage_if.sv
// Stage-1 fetch bus: branch/bubble control in, instruction-memory port, stage-2 latch out.
// master = fetch_stage side, slave = surrounding pipeline / memory side.
interface fetch_stage_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               bb;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] st2_ir;
  logic [ADDR_W-1:0]  st2_pc;
  logic               st2_valid;
  logic [2:0]         st2_op;
  logic [15:0]        bubble_cnt;

  modport master (
    input  bb, br_taken, br_target, imem_data,
    output imem_addr, st2_ir, st2_pc, st2_valid, st2_op, bubble_cnt
  );

  modport slave (
    output bb, br_taken, br_target, imem_data,
    input  imem_addr, st2_ir, st2_pc, st2_valid, st2_op, bubble_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// Stage-1 instruction fetch: PC generation, synchronous imem addressing and the stage-2 latch.
// Optional macro FETCH_BUBBLE_STATS_EN enables the saturating bubble counter on bubble_cnt.
module fetch_stage #(
  parameter int                  ADDR_W    = 8,
  parameter int                  INSTR_W   = 16,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master fif
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  fpc_q, fpc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  spc_q, spc_d;
  logic               vld_q, vld_d;
  logic               load_bubble;

  // During a hold the word in flight is re-read so imem_data stays put.
  assign fif.imem_addr = (state_q != FILL && fif.bb && !fif.br_taken) ? fpc_q : pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fpc_d       = fpc_q;
    ir_d        = ir_q;
    spc_d       = spc_q;
    vld_d       = vld_q;
    load_bubble = 1'b0;
    if (fif.br_taken) begin
      pc_d        = fif.br_target;
      ir_d        = NOP_INSTR;
      vld_d       = 1'b0;
      state_d     = FILL;
      load_bubble = 1'b1;
    end else if (fif.bb) begin
      ir_d        = NOP_INSTR;
      vld_d       = 1'b0;
      load_bubble = 1'b1;
      if (state_q == RUN) state_d = HOLD;
    end else if (state_q == FILL) begin
      ir_d        = NOP_INSTR;
      vld_d       = 1'b0;
      load_bubble = 1'b1;
      fpc_d       = pc_q;
      pc_d        = pc_q + 1'b1;
      state_d     = RUN;
    end else begin
      ir_d    = fif.imem_data;
      spc_d   = fpc_q;
      vld_d   = 1'b1;
      fpc_d   = pc_q;
      pc_d    = pc_q + 1'b1;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      pc_q    <= RESET_PC;
      fpc_q   <= RESET_PC;
      ir_q    <= NOP_INSTR;
      spc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
      ir_q    <= ir_d;
      spc_q   <= spc_d;
      vld_q   <= vld_d;
    end
  end

  assign fif.st2_ir    = ir_q;
  assign fif.st2_pc    = spc_q;
  assign fif.st2_valid = vld_q;
  assign fif.st2_op    = ir_q[INSTR_W-1 -: 3];

`ifdef FETCH_BUBBLE_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (load_bubble) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign fif.bubble_cnt = cnt_q;
`else
  assign fif.bubble_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus a random phase against a
// transaction-level model of the fetch stream (next address, one word in flight).
module tb_fetch_stage;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam logic [15:0] NOP = 16'h0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) fif ();

  fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
  );

  logic [15:0] mem [256];
  always @(posedge clk) fif.imem_data <= mem[fif.imem_addr];

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        vld;
    logic [15:0] cnt;
  } rec_t;
  rec_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference: next address to fetch, plus the one address whose word is (or will be) on imem_data.
  logic [7:0]  m_pc, m_infl, m_spc;
  logic        m_infl_ok, m_vld;
  logic [15:0] m_ir, m_cnt;

  task automatic model_reset();
    m_pc = 8'h00; m_infl = 8'h00; m_infl_ok = 1'b0;
    m_ir = NOP; m_spc = 8'h00; m_vld = 1'b0; m_cnt = 16'd0;
  endtask

  task automatic model_bubble();
    m_ir = NOP;
    m_vld = 1'b0;
`ifdef FETCH_BUBBLE_STATS_EN
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
  endtask

  task automatic model_step(input bit b, input bit t, input logic [7:0] tgt);
    if (t) begin
      model_bubble();
      m_pc = tgt;
      m_infl_ok = 1'b0;
    end else if (b) begin
      model_bubble();
    end else begin
      if (m_infl_ok) begin
        m_ir  = mem[m_infl];
        m_spc = m_infl;
        m_vld = 1'b1;
      end else begin
        model_bubble();
      end
      m_infl    = m_pc;
      m_infl_ok = 1'b1;
      m_pc      = m_pc + 8'd1;
    end
  endtask

  // One clock of stimulus; the record captures what the DUT must show until the next edge.
  task automatic cyc(input bit r, input bit b, input bit t, input logic [7:0] tgt);
    rec_t rec;
    @(posedge clk);
    #2;
    rst_n = r; fif.bb = b; fif.br_taken = t; fif.br_target = tgt;
    if (!r) model_reset();
    rec.addr = (b && !t && m_infl_ok) ? m_infl : m_pc;
    rec.ir   = m_ir;
    rec.pc   = m_spc;
    rec.vld  = m_vld;
    rec.cnt  = m_cnt;
    sb.push_back(rec);
    if (r) model_step(b, t, tgt);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      rec_t e;
      e = sb.pop_front();
      chk("imem_addr", 32'(fif.imem_addr), 32'(e.addr));
      chk("st2_valid", 32'(fif.st2_valid), 32'(e.vld));
      chk("st2_ir",    32'(fif.st2_ir),    32'(e.ir));
      chk("st2_pc",    32'(fif.st2_pc),    32'(e.pc));
      chk("st2_op",    32'(fif.st2_op),    32'(e.ir[15:13]));
      chk("bubble_cnt",32'(fif.bubble_cnt),32'(e.cnt));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = (i < 16) ? 16'h1000 + 16'(i) : 16'($urandom);
    fif.bb = 1'b0; fif.br_taken = 1'b0; fif.br_target = 8'h00;
    model_reset();

    // Reset held, then free run from address 0.
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'h00);
    // Hold for three cycles, then release.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h00);
    // Plain redirect.
    cyc(1, 0, 1, 8'h40);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h00);
    // Redirect together with a bubble request.
    cyc(1, 1, 1, 8'h20);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h00);
    // Wrap-around of the address space.
    cyc(1, 0, 1, 8'hFE);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'h00);
    // Bubble request while still filling after a redirect.
    cyc(1, 0, 1, 8'h80);
    cyc(1, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h00);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit b, t;
      b = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 9) == 0);
      cyc(1, b, t, 8'($urandom));
    end
    // Reset asserted in the middle of a hold.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'h00);
    cyc(1, 1, 0, 8'h00);
    cyc(1, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    cyc(1, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'h00);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
